// File: rtl/axil_rr_master_arb.sv
// axil_rr_master_arb: two-requester round-robin arbiter that serializes single-word
// read/write commands onto one AXI4-Lite master port. One transaction is in flight
// at a time, and each completion is reported as a one-cycle pulse to its owner.
//
// Ports:
//   ACLK, ARESETN          clock and synchronous active-low reset
//   reqN_*                 command port per requester (valid/ready, write, addr, wdata, wstrb)
//   rspN_*                 completion pulse per requester, with read data and response code
//   M_AXI_*                AXI4-Lite master (AW/W/B, AR/R)
//
// Optional build macro AXIL_ARB_TIMEOUT_EN: a watchdog aborts any AXI phase after
// TIMEOUT_CYCLES cycles and completes the command with SLVERR and zero read data.
module axil_rr_master_arb #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic                    req0_write,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic [DATA_WIDTH-1:0]   req0_wdata,
    input  logic [DATA_WIDTH/8-1:0] req0_wstrb,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic                    req1_write,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,
    input  logic [DATA_WIDTH-1:0]   req1_wdata,
    input  logic [DATA_WIDTH/8-1:0] req1_wstrb,
    output logic                    rsp0_valid,
    output logic [DATA_WIDTH-1:0]   rsp0_rdata,
    output logic [1:0]              rsp0_resp,
    output logic                    rsp1_valid,
    output logic [DATA_WIDTH-1:0]   rsp1_rdata,
    output logic [1:0]              rsp1_resp,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    typedef enum logic [2:0] {StIdle, StWrAwW, StWrB, StRdAr, StRdR, StRsp} state_e;

    state_e                  state_q, state_d;
    logic                    prio_q, prio_d;
    logic                    owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic                    bready_q, bready_d, rready_q, rready_d;
    logic                    rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;

    logic gnt0, gnt1, aw_done, w_done, timeout;

    // Priority holder wins a tie; a lone valid always wins.
    assign gnt0 = req0_valid & (~prio_q | ~req1_valid);
    assign gnt1 = req1_valid & (prio_q | ~req0_valid);

    assign req0_ready = (state_q == StIdle) & gnt0;
    assign req1_ready = (state_q == StIdle) & gnt1;

    // A channel counts as done once its VALID has dropped or is handshaking now.
    assign aw_done = ~awvalid_q | M_AXI_AWREADY;
    assign w_done  = ~wvalid_q | M_AXI_WREADY;

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            counting;

    assign counting = (state_q == StWrAwW) | (state_q == StWrB) |
                      (state_q == StRdAr) | (state_q == StRdR);
    assign timeout  = counting & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // Restart on every state change so each AXI phase gets the full budget.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && counting) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        bready_d     = bready_q;
        rready_d     = rready_q;
        rdata_d      = rdata_q;
        resp_d       = resp_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (gnt0 | gnt1) begin
                    owner_d = gnt1;
                    prio_d  = ~gnt1;
                    addr_d  = gnt1 ? req1_addr : req0_addr;
                    wdata_d = gnt1 ? req1_wdata : req0_wdata;
                    wstrb_d = gnt1 ? req1_wstrb : req0_wstrb;
                    if (gnt1 ? req1_write : req0_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWrAwW;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRdAr;
                    end
                end
            end
            StWrAwW: begin
                if (aw_done & w_done) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = StWrB;
                end else if (timeout) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                end else begin
                    awvalid_d = awvalid_q & ~M_AXI_AWREADY;
                    wvalid_d  = wvalid_q & ~M_AXI_WREADY;
                end
            end
            StWrB: begin
                if (M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    rdata_d  = '0;
                    resp_d   = M_AXI_BRESP;
                end else if (timeout) begin
                    bready_d = 1'b0;
                end
            end
            StRdAr: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdR;
                end else if (timeout) begin
                    arvalid_d = 1'b0;
                end
            end
            StRdR: begin
                if (M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    rdata_d  = M_AXI_RDATA;
                    resp_d   = M_AXI_RRESP;
                end else if (timeout) begin
                    rready_d = 1'b0;
                end
            end
            StRsp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Common completion path: normal response or watchdog abort.
        if ((state_q == StWrB && M_AXI_BVALID) || (state_q == StRdR && M_AXI_RVALID) ||
            (timeout && !(state_q == StWrAwW && aw_done && w_done) &&
             !(state_q == StRdAr && M_AXI_ARREADY))) begin
            if (timeout && !(state_q == StWrB && M_AXI_BVALID) &&
                !(state_q == StRdR && M_AXI_RVALID)) begin
                rdata_d = '0;
                resp_d  = 2'b10;
            end
            rsp0_valid_d = ~owner_q;
            rsp1_valid_d = owner_q;
            state_d      = StRsp;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q      <= StIdle;
            prio_q       <= 1'b0;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            rready_q     <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            bready_q     <= bready_d;
            rready_q     <= rready_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign rsp0_valid    = rsp0_valid_q;
    assign rsp1_valid    = rsp1_valid_q;
    assign rsp0_rdata    = rdata_q;
    assign rsp1_rdata    = rdata_q;
    assign rsp0_resp     = resp_q;
    assign rsp1_resp     = resp_q;

endmodule

// File: doc/axil_rr_master_arb.md
# axil_rr_master_arb

Two-requester round-robin arbiter and sequencer that shares a single AXI4-Lite master port into the WR register slave (S00_AXI, four 32-bit registers). Each requester issues single-word read or write commands over a valid/ready port and receives a one-cycle response pulse. The block keeps one transaction outstanding and drives AW/W/B or AR/R handshakes to completion. It sits between on-chip control logic and the WR slave's S00_AXI port in the block design.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (fixed 32; WSTRB is 4 bits)
- TIMEOUT_CYCLES, 256, watchdog limit in cycles (used only with AXIL_ARB_TIMEOUT_EN)
- ACLK  in  1  single clock, rising edge
- ARESETN  in  1  reset, synchronous, active-low
- req0_valid / req1_valid  in  1  command valid
- req0_ready / req1_ready  out  1  command accepted this cycle
- req0_write / req1_write  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  ADDR_WIDTH  byte address
- req0_wdata / req1_wdata  in  32  write data
- req0_wstrb / req1_wstrb  in  4  write byte strobes
- rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse
- rsp0_rdata / rsp1_rdata  out  32  read data, valid with rspN_valid (0 for writes)
- rsp0_resp / rsp1_resp  out  2  BRESP/RRESP, valid with rspN_valid
- M_AXI_AWADDR out ADDR_WIDTH, M_AXI_AWPROT out 3, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1
- M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1
- M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1
- M_AXI_ARADDR out ADDR_WIDTH, M_AXI_ARPROT out 3, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1
- M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1

## Operation
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE: reqN_ready = 1 combinationally only for the granted requester; grant = requester holding priority if its valid is high, else the other if valid. Handshake captures write/addr/wdata/wstrb and owner ID; next state WR_AW_W (write) or RD_AR (read).
- Round-robin: priority pointer resets to 0; after a grant to N, priority moves to the other requester. Simultaneous valids alternate strictly.
- WR_AW_W: AWVALID and WVALID assert together; each deasserts independently on its own handshake; when both done -> WR_B. AW before W, W before AW, and same-cycle are all legal.
- WR_B: BREADY = 1; on BVALID capture BRESP, rdata = 0 -> RSP.
- RD_AR: ARVALID = 1 until ARREADY -> RD_R. RD_R: RREADY = 1; on RVALID capture RDATA/RRESP -> RSP.
- RSP: rspN_valid = 1 for owner for exactly one cycle; rdata/resp held until next completion; -> IDLE.
- AWPROT = ARPROT = 3'b000 constant. Address/data outputs held stable while the corresponding VALID is high.
- One outstanding transaction; reqN_ready = 0 in every state except IDLE.

## Timing
- Reset (ARESETN low at rising edge): state IDLE, priority 0; all VALID/READY outputs, rspN_valid, rspN_rdata, rspN_resp, AXI address/data outputs = 0. Reset mid-transaction abandons it without a response; no pulse after release.
- Accept at cycle T -> AWVALID/WVALID (or ARVALID) high at T+1.
- Zero-wait slave write: AW/W handshake at T+1, B at T+2, rsp_valid at T+3, IDLE at T+4 (next accept at T+4). Read identical with AR/R.
- BREADY/RREADY are registered and high for the whole WR_B/RD_R state.
- Back-to-back throughput, zero-wait slave: one transaction per 4 cycles.

## Configuration
- AXIL_ARB_TIMEOUT_EN defined: cycle counter resets on every state entry and counts in WR_AW_W, WR_B, RD_AR, RD_R; reaching TIMEOUT_CYCLES drops all AXI VALID/READY outputs, goes to RSP with resp = 2'b10 (SLVERR), rdata = 0. Late slave responses after a timeout are ignored.
- Not defined: no counter; the block waits indefinitely for the slave.

## Test plan
- Req0 write 0x0101FFFF, wstrb 0xF, addr 0x0, zero-wait slave -> AWVALID/WVALID at T+1, rsp0_valid at T+3 with resp 2'b00; read of 0x0 -> rsp0_rdata 0x0101FFFF.
- Both requesters valid every cycle (req0 write 0xABCD0001 to 0x4, req1 read 0x4) -> grants strictly 0,1,0,1; req1 reads 0xABCD0001; no response pulse to the wrong requester.
- Slave asserts WREADY 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID held; single B handshake; one rsp pulse.
- Slave returns RRESP 2'b10 with RDATA 0xDEAD0011 -> rsp1_resp 2'b10, rsp1_rdata 0xDEAD0011.
- ARESETN low while in WR_B -> next cycle all outputs 0, no rsp pulse; next request after release is granted to requester 0.
- With AXIL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES 16, slave never asserts ARREADY -> ARVALID drops after 16 cycles, rsp_valid with resp 2'b10, rdata 0.
